// File: rtl/mem_trace_buf_pkg.sv
// mem_trace_buf_pkg
//   Shared definitions for the load/store trace buffer:
//   - access size encodings carried on cap_size / rd_size
//   - overflow mode encodings carried on mode
//   - bit layout of one packed trace record in storage
//     (we at bit 0, size at [2:1], data, then addr, then optional timestamp)
//   No ports; imported by mem_trace_buf and mem_trace_buf_trace_ram.

package mem_trace_buf_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_e;

   typedef enum logic {
      MODE_STOP = 1'b0,
      MODE_WRAP = 1'b1
   } mode_e;

   // Fixed low fields of a record
   localparam int REC_WE_LSB   = 0;
   localparam int REC_SIZE_LSB = 1;
   localparam int REC_DATA_LSB = 3;

   // Width-dependent field offsets
   function automatic int rec_addr_lsb(input int data_w);
      return REC_DATA_LSB + data_w;
   endfunction

   function automatic int rec_ts_lsb(input int addr_w, input int data_w);
      return rec_addr_lsb(data_w) + addr_w;
   endfunction

   // Total record width; ts_w is 0 when timestamps are not stored
   function automatic int rec_width(input int addr_w, input int data_w, input int ts_w);
      return rec_ts_lsb(addr_w, data_w) + ts_w;
   endfunction

endpackage

// File: rtl/mem_trace_buf_trace_ram.sv
// mem_trace_buf_trace_ram
//   DEPTH x WIDTH register array holding packed trace records.
//   One synchronous write port, one asynchronous (combinational) read port
//   so the buffer head can be presented fall-through.
// Ports:
//   clk    in   system clock, write on rising edge
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   record to write
//   raddr  in   read index
//   rdata  out  record at raddr (combinational)

module mem_trace_buf_trace_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 67
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage is intentionally not reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_trace_buf.sv
// mem_trace_buf
//   Circular trace buffer capturing one record per completed data access
//   (address, size-masked data, size, load/store flag) while armed.
//   Records drain through a fall-through valid/ready read port.
//   mode selects stop-when-full (drop new) or overwrite-oldest; a sticky
//   overflow flag records any dropped or overwritten record.
//   Optional build macro: TRACE_TIMESTAMP_EN adds a free-running TS_W-bit
//   cycle counter stored with every record and presented on rd_ts.
// Ports:
//   clk, rst (async, active-low)
//   cap_valid/cap_addr/cap_data/cap_size/cap_we : capture input
//   arm, disarm, clr : control pulses; mode : 0 stop, 1 wrap
//   rd_valid/rd_ready, rd_addr/rd_data/rd_size/rd_we : head entry
//   [rd_ts] : head entry timestamp (TRACE_TIMESTAMP_EN only)
//   count : entries held; armed : capture enabled; overflow : sticky loss

module mem_trace_buf
   import mem_trace_buf_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cap_valid,
   input  logic [ADDR_W-1:0]        cap_addr,
   input  logic [DATA_W-1:0]        cap_data,
   input  logic [1:0]               cap_size,
   input  logic                     cap_we,
   input  logic                     arm,
   input  logic                     disarm,
   input  logic                     mode,
   input  logic                     clr,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [ADDR_W-1:0]        rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic [1:0]               rd_size,
   output logic                     rd_we,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     armed,
   output logic                     overflow
`ifdef TRACE_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]          rd_ts
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
`ifdef TRACE_TIMESTAMP_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif
   localparam int TS_BITS  = TS_EN ? TS_W : 0;
   localparam int ADDR_LSB = rec_addr_lsb(DATA_W);
   localparam int REC_W    = rec_width(ADDR_W, DATA_W, TS_BITS);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             armed_reg, armed_next;
   logic             overflow_reg, overflow_next;

   logic             push, pop, full, empty;
   logic             wr_en;
   logic [DATA_W-1:0] masked_data;
   logic [REC_W-1:0]  wr_rec, rd_rec;

   assign full  = (count_reg == FULL_CNT);
   assign empty = (count_reg == '0);
   assign push  = armed_reg & cap_valid;
   assign pop   = ~empty & rd_ready;

   // Size masking: narrow accesses keep only their low bytes, zero-extended.
   always_comb begin
      masked_data = '0;
      if (cap_size == SIZE_BYTE) begin
         masked_data[7:0] = cap_data[7:0];
      end else if (cap_size == SIZE_HALF) begin
         masked_data[15:0] = cap_data[15:0];
      end else begin
         masked_data = cap_data;
      end
   end

`ifdef TRACE_TIMESTAMP_EN
   localparam int TS_LSB = rec_ts_lsb(ADDR_W, DATA_W);
   logic [TS_W-1:0] ts_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts_reg <= '0;
      end else begin
         ts_reg <= ts_reg + TS_W'(1);
      end
   end

   assign rd_ts = rd_rec[TS_LSB +: TS_W];
`endif

   always_comb begin
      wr_rec = '0;
      wr_rec[REC_WE_LSB]              = cap_we;
      wr_rec[REC_SIZE_LSB +: 2]       = cap_size;
      wr_rec[REC_DATA_LSB +: DATA_W]  = masked_data;
      wr_rec[ADDR_LSB +: ADDR_W]      = cap_addr;
`ifdef TRACE_TIMESTAMP_EN
      wr_rec[TS_LSB +: TS_W]          = ts_reg;
`endif
   end

   // Pointer/count control. clr dominates; otherwise push and pop are
   // resolved together so that full+push+pop behaves as a plain shift.
   always_comb begin
      head_next     = head_reg;
      tail_next     = tail_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;
      wr_en         = 1'b0;
      armed_next    = armed_reg;

      if (disarm) begin
         armed_next = 1'b0;
      end else if (arm) begin
         armed_next = 1'b1;
      end

      if (clr) begin
         head_next     = '0;
         tail_next     = '0;
         count_next    = '0;
         overflow_next = 1'b0;
      end else begin
         if (push) begin
            if (!full || pop) begin
               // A concurrent pop frees the slot, so no record is lost.
               wr_en     = 1'b1;
               tail_next = tail_reg + PTR_W'(1);
               if (!pop) begin
                  count_next = count_reg + CNT_W'(1);
               end
            end else if (mode == MODE_WRAP) begin
               // Full with tail == head: overwrite oldest and drag head along.
               wr_en         = 1'b1;
               tail_next     = tail_reg + PTR_W'(1);
               head_next     = head_reg + PTR_W'(1);
               overflow_next = 1'b1;
            end else begin
               overflow_next = 1'b1;
            end
         end
         if (pop) begin
            head_next = head_reg + PTR_W'(1);
            if (!push) begin
               count_next = count_reg - CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         armed_reg    <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         head_reg     <= head_next;
         tail_reg     <= tail_next;
         count_reg    <= count_next;
         armed_reg    <= armed_next;
         overflow_reg <= overflow_next;
      end
   end

   mem_trace_buf_trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_trace_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (tail_reg),
      .wdata (wr_rec),
      .raddr (head_reg),
      .rdata (rd_rec)
   );

   assign rd_valid = ~empty;
   assign rd_we    = rd_rec[REC_WE_LSB];
   assign rd_size  = rd_rec[REC_SIZE_LSB +: 2];
   assign rd_data  = rd_rec[REC_DATA_LSB +: DATA_W];
   assign rd_addr  = rd_rec[ADDR_LSB +: ADDR_W];
   assign count    = count_reg;
   assign armed    = armed_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_mem_trace_buf.sv
// tb_mem_trace_buf
//   Directed bench for mem_trace_buf (default build, DEPTH 16, 32-bit).
//   Inputs change 1 ns after a rising edge; outputs are checked 1 ns after
//   the following rising edge.

module tb_mem_trace_buf;

   logic        clk;
   logic        rst;
   logic        cap_valid;
   logic [31:0] cap_addr;
   logic [31:0] cap_data;
   logic [1:0]  cap_size;
   logic        cap_we;
   logic        arm;
   logic        disarm;
   logic        mode;
   logic        clr;
   logic        rd_ready;
   logic        rd_valid;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  rd_size;
   logic        rd_we;
   logic [4:0]  count;
   logic        armed;
   logic        overflow;

   int vectors;
   int miscompares;

   mem_trace_buf #(
      .ADDR_W (32),
      .DATA_W (32),
      .DEPTH  (16),
      .TS_W   (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cap_valid (cap_valid),
      .cap_addr  (cap_addr),
      .cap_data  (cap_data),
      .cap_size  (cap_size),
      .cap_we    (cap_we),
      .arm       (arm),
      .disarm    (disarm),
      .mode      (mode),
      .clr       (clr),
      .rd_ready  (rd_ready),
      .rd_valid  (rd_valid),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_size   (rd_size),
      .rd_we     (rd_we),
      .count     (count),
      .armed     (armed),
      .overflow  (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rec(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s, input logic w);
      cap_valid = 1'b1;
      cap_addr  = a;
      cap_data  = d;
      cap_size  = s;
      cap_we    = w;
      step();
      cap_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cap_valid = 0; cap_addr = 0; cap_data = 0; cap_size = 0; cap_we = 0;
      arm = 0; disarm = 0; mode = 0; clr = 0; rd_ready = 0;
      step();
      step();
      vectors++;
      if (rd_valid !== 1'b0 || count !== 5'd0 || armed !== 1'b0 || overflow !== 1'b0) begin
         $display("FAIL reset_state: got valid=%b count=%0d armed=%b ovf=%b expected 0 0 0 0",
                  rd_valid, count, armed, overflow);
         miscompares++;
      end
      rst = 1'b1;
      step();
      $display("reset: valid=%b count=%0d armed=%b overflow=%b", rd_valid, count, armed, overflow);
   endtask

   task automatic test_word_load();
      arm = 1'b1;
      step();
      arm = 1'b0;
      vectors++;
      if (armed !== 1'b1) begin
         $display("FAIL arm: got %b expected 1", armed);
         miscompares++;
      end
      push_rec(32'h100, 32'hDEADBEEF, 2'b10, 1'b0);
      vectors++;
      if (rd_valid !== 1'b1 || rd_addr !== 32'h100 || rd_data !== 32'hDEADBEEF ||
          rd_size !== 2'b10 || rd_we !== 1'b0 || count !== 5'd1) begin
         $display("FAIL word_load: got v=%b a=%h d=%h s=%b we=%b c=%0d expected 1 100 deadbeef 10 0 1",
                  rd_valid, rd_addr, rd_data, rd_size, rd_we, count);
         miscompares++;
      end
      $display("word_load: addr=%h data=%h size=%b we=%b count=%0d", rd_addr, rd_data, rd_size, rd_we, count);
      rd_ready = 1'b1;
      step();
      vectors++;
      if (rd_valid !== 1'b0 || count !== 5'd0) begin
         $display("FAIL pop_single: got v=%b c=%0d expected 0 0", rd_valid, count);
         miscompares++;
      end
      // Pop while empty must be ignored
      step();
      rd_ready = 1'b0;
      vectors++;
      if (rd_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b0) begin
         $display("FAIL pop_empty: got v=%b c=%0d ovf=%b expected 0 0 0", rd_valid, count, overflow);
         miscompares++;
      end
      $display("pop_empty: count=%0d", count);
   endtask

   task automatic test_masking();
      push_rec(32'h200, 32'h12345678, 2'b00, 1'b1);
      push_rec(32'h204, 32'hCAFEF00D, 2'b01, 1'b1);
      vectors++;
      if (count !== 5'd2 || rd_data !== 32'h00000078 || rd_we !== 1'b1 || rd_size !== 2'b00) begin
         $display("FAIL mask_byte: got c=%0d d=%h we=%b s=%b expected 2 00000078 1 00",
                  count, rd_data, rd_we, rd_size);
         miscompares++;
      end
      $display("mask_byte: data=%h we=%b", rd_data, rd_we);
      rd_ready = 1'b1;
      step();
      vectors++;
      if (rd_data !== 32'h0000F00D || rd_we !== 1'b1 || rd_size !== 2'b01 || rd_addr !== 32'h204) begin
         $display("FAIL mask_half: got d=%h we=%b s=%b a=%h expected 0000f00d 1 01 204",
                  rd_data, rd_we, rd_size, rd_addr);
         miscompares++;
      end
      $display("mask_half: data=%h we=%b", rd_data, rd_we);
      step();
      rd_ready = 1'b0;
      vectors++;
      if (count !== 5'd0) begin
         $display("FAIL mask_drain: got %0d expected 0", count);
         miscompares++;
      end
   endtask

   task automatic fill_and_drain(input logic m, input int first);
      mode = m;
      for (int i = 0; i < 20; i++) begin
         push_rec(32'(i), 32'(i), 2'b10, 1'b0);
      end
      vectors++;
      if (count !== 5'd16 || overflow !== 1'b1) begin
         $display("FAIL fill_mode%0d: got c=%0d ovf=%b expected 16 1", m, count, overflow);
         miscompares++;
      end
      $display("fill_mode%0d: count=%0d overflow=%b", m, count, overflow);
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if (rd_valid !== 1'b1 || rd_addr !== 32'(first + i)) begin
            $display("FAIL drain_mode%0d[%0d]: got v=%b a=%h expected 1 %h",
                     m, i, rd_valid, rd_addr, 32'(first + i));
            miscompares++;
         end
         step();
      end
      rd_ready = 1'b0;
      vectors++;
      if (count !== 5'd0 || rd_valid !== 1'b0) begin
         $display("FAIL drained_mode%0d: got c=%0d v=%b expected 0 0", m, count, rd_valid);
         miscompares++;
      end
      pulse_clr();
      vectors++;
      if (overflow !== 1'b0) begin
         $display("FAIL clr_overflow: got %b expected 0", overflow);
         miscompares++;
      end
      $display("drain_mode%0d: first=%0d overflow_after_clr=%b", m, first, overflow);
   endtask

   task automatic test_stop_mode();
      fill_and_drain(1'b0, 0);
   endtask

   task automatic test_wrap_mode();
      fill_and_drain(1'b1, 4);
   endtask

   task automatic test_full_push_pop();
      mode = 1'b0;
      for (int i = 0; i < 16; i++) begin
         push_rec(32'h200 + 32'(i), 32'(i), 2'b10, 1'b0);
      end
      vectors++;
      if (count !== 5'd16 || overflow !== 1'b0 || rd_addr !== 32'h200) begin
         $display("FAIL full_exact: got c=%0d ovf=%b a=%h expected 16 0 200", count, overflow, rd_addr);
         miscompares++;
      end
      rd_ready = 1'b1;
      push_rec(32'h300, 32'h3, 2'b10, 1'b0);
      rd_ready = 1'b0;
      vectors++;
      if (count !== 5'd16 || overflow !== 1'b0 || rd_addr !== 32'h201) begin
         $display("FAIL full_push_pop: got c=%0d ovf=%b a=%h expected 16 0 201", count, overflow, rd_addr);
         miscompares++;
      end
      $display("full_push_pop: count=%0d overflow=%b head=%h", count, overflow, rd_addr);
      rd_ready = 1'b1;
      for (int i = 0; i < 15; i++) step();
      rd_ready = 1'b0;
      vectors++;
      if (count !== 5'd1 || rd_addr !== 32'h300) begin
         $display("FAIL full_push_pop_tail: got c=%0d a=%h expected 1 300", count, rd_addr);
         miscompares++;
      end
      // clr wins over a simultaneous push
      clr = 1'b1;
      cap_valid = 1'b1;
      step();
      clr = 1'b0;
      cap_valid = 1'b0;
      vectors++;
      if (count !== 5'd0 || rd_valid !== 1'b0 || armed !== 1'b1) begin
         $display("FAIL clr_priority: got c=%0d v=%b armed=%b expected 0 0 1", count, rd_valid, armed);
         miscompares++;
      end
      $display("clr_priority: count=%0d armed=%b", count, armed);
   endtask

   task automatic test_disarm_and_async_reset();
      push_rec(32'h40, 32'h1, 2'b10, 1'b0);
      push_rec(32'h44, 32'h2, 2'b10, 1'b0);
      disarm = 1'b1;
      step();
      disarm = 1'b0;
      for (int i = 0; i < 3; i++) push_rec(32'h50 + 32'(i), 32'h9, 2'b10, 1'b1);
      vectors++;
      if (armed !== 1'b0 || count !== 5'd2) begin
         $display("FAIL disarm: got armed=%b c=%0d expected 0 2", armed, count);
         miscompares++;
      end
      arm = 1'b1;
      disarm = 1'b1;
      step();
      arm = 1'b0;
      disarm = 1'b0;
      vectors++;
      if (armed !== 1'b0) begin
         $display("FAIL arm_disarm_same: got %b expected 0", armed);
         miscompares++;
      end
      $display("disarm: armed=%b count=%0d", armed, count);
      // Re-arm; arm must not clear the buffer. Then overfill to set overflow.
      arm = 1'b1;
      step();
      arm = 1'b0;
      vectors++;
      if (count !== 5'd2 || rd_addr !== 32'h40) begin
         $display("FAIL arm_keeps: got c=%0d a=%h expected 2 40", count, rd_addr);
         miscompares++;
      end
      for (int i = 0; i < 15; i++) push_rec(32'h80 + 32'(i), 32'h0, 2'b10, 1'b0);
      vectors++;
      if (count !== 5'd16 || overflow !== 1'b1 || armed !== 1'b1) begin
         $display("FAIL pre_reset: got c=%0d ovf=%b armed=%b expected 16 1 1", count, overflow, armed);
         miscompares++;
      end
      // Assert reset mid-cycle and check before any clock edge.
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if (count !== 5'd0 || armed !== 1'b0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
         $display("FAIL async_reset: got c=%0d armed=%b ovf=%b v=%b expected 0 0 0 0",
                  count, armed, overflow, rd_valid);
         miscompares++;
      end
      $display("async_reset: count=%0d armed=%b overflow=%b", count, armed, overflow);
      step();
      rst = 1'b1;
      step();
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_word_load();
      test_masking();
      test_stop_mode();
      test_wrap_mode();
      test_full_push_pop();
      test_disarm_and_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_trace_buf.md
Name: mem_trace_buf

Overview:
- Synthesizable load/store trace buffer for the RISC-V SoC; replaces simulation-only $display monitoring of the processor's data-access phase.
- Captures one record per completed data access (address, data, size, load/store) into a circular buffer.
- Records are drained through a valid/ready read port, e.g. by a UART dumper or a debug register window.
- Generalised in address/data width and depth, with stop-on-full and overwrite-oldest modes.

Parameters:
- ADDR_W, 32, width of captured address.
- DATA_W, 32, width of captured data; must be ≥16.
- DEPTH, 16, number of entries; power of two, ≥2.
- TS_W, 16, timestamp width; used only with TRACE_TIMESTAMP_EN.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-low.
- cap_valid  in  1  access completes this cycle.
- cap_addr  in  ADDR_W  access address.
- cap_data  in  DATA_W  loaded or stored data.
- cap_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- cap_we  in  1  1 = store, 0 = load.
- arm  in  1  pulse: start capturing.
- disarm  in  1  pulse: stop capturing.
- mode  in  1  0 = stop when full, 1 = overwrite oldest.
- clr  in  1  pulse: empty buffer, clear overflow.
- rd_ready  in  1  consumer accepts head entry.
- rd_valid  out  1  buffer non-empty.
- rd_addr  out  ADDR_W  head entry address.
- rd_data  out  DATA_W  head entry data.
- rd_size  out  2  head entry size.
- rd_we  out  1  head entry store flag.
- count  out  $clog2(DEPTH)+1  entries held.
- armed  out  1  capture enabled.
- overflow  out  1  sticky: a record was dropped or overwritten.

Behaviour:
- Reset (rst low, asynchronous): pointers 0, count 0, armed 0, overflow 0, rd_valid 0.
  - Storage array is not reset; rd_addr, rd_data, rd_size and rd_we are don't-care while rd_valid = 0.
  - Reset mid-capture discards all entries.
- Arm/disarm:
  - armed is set on arm and cleared on disarm.
  - If both are asserted in the same cycle, disarm wins.
  - arm does not clear the buffer.
- Push condition: armed and cap_valid in the cycle. A push is visible on rd_valid/count the following cycle (1-cycle latency).
- Data masking at capture:
  - byte: stores cap_data[7:0] zero-extended.
  - half: stores cap_data[15:0] zero-extended.
  - word: stores full width.
  - Address is stored unmodified.
- Pop condition: rd_valid and rd_ready. The head advances next cycle. rd_* are driven combinationally from the head entry (fall-through).
- Pop when empty: ignored, no state change.
- Push when full, mode 0: record dropped, overflow set, count stays DEPTH.
- Push when full, mode 1: tail overwrites the oldest entry, head advances, overflow set, count stays DEPTH.
- Simultaneous push and pop:
  - Not full: count unchanged, both pointers advance.
  - Full: both proceed, count stays DEPTH, no overflow, no overwrite.
- Pointers wrap modulo DEPTH. Full/empty are derived from count.
- clr:
  - Empties the buffer (pointers 0, count 0) and clears overflow.
  - Has priority over push/pop in the same cycle.
  - armed is unaffected.
- mode may change at any time; it takes effect on the next push.

Optional Feature:
- TRACE_TIMESTAMP_EN defined:
  - Adds a free-running TS_W-bit cycle counter. It resets to 0, increments every cycle and wraps 2^TS_W−1 → 0.
  - Each push stores the counter value of the capture cycle.
  - Adds output rd_ts [TS_W-1:0] for the head entry.
- Not defined: no counter, no rd_ts port, no extra storage.

Decomposition:
- Shared package/header holds:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - the mode encodings MODE_STOP=0 and MODE_WRAP=1;
  - the record field layout (bit offsets of addr, data, size, we, ts) for packing into one storage word.
- One sub-module is natural: trace_ram, a DEPTH × record-width register array with one synchronous write port and one asynchronous read port. Pointer, count and control logic stay in mem_trace_buf.

Test Plan:
- Reset, then arm. Push word load addr=0x100 data=0xDEADBEEF; next cycle → rd_valid=1, rd_addr=0x100, rd_data=0xDEADBEEF, rd_size=10, rd_we=0, count=1.
- Push byte store data=0x12345678 size=00, then halfword data=0xCAFEF00D size=01 → popped rd_data 0x00000078 then 0x0000F00D, rd_we=1 both.
- mode=0, DEPTH=16: push 20 records with addr=0..19 → count=16, overflow=1; pops return addr 0..15.
- mode=1, DEPTH=16: push 20 records with addr=0..19 → count=16, overflow=1; pops return addr 4..19.
- Buffer full (16) with rd_ready=1 and cap_valid=1 in the same cycle → count stays 16, overflow stays 0, head advances by one.
- Disarm, push 3 records → count unchanged. Pulse rst low mid-sequence → count=0, armed=0, overflow=0 immediately, without waiting for a clock edge.
